// File: rtl/detector_jogada.sv
// Purpose : synchronise and debounce the note buttons, emit one tem_jogada pulse per accepted press.
// Latency : raw change -> botoes_estaveis after DEBOUNCE_CICLOS+3 edges; tem_jogada one edge later.
// Backpr. : none; tem_jogada is a one-cycle pulse, jogada is held until the next capture or limpa_jogada.
//
// Ports:
//   clock, reset           : rising-edge clock, synchronous active-high reset
//   botoes                 : raw asynchronous buttons (1 = pressed)
//   habilita               : 1 lets a press become a jogada; 0 swallows the press
//   limpa_jogada           : clears jogada / jogada_multipla (a same-edge capture wins)
//   tem_botao_pressionado  : OR of botoes_estaveis
//   tem_jogada             : one-cycle pulse per accepted press
//   jogada                 : one-hot lowest pressed button at capture time
//   jogada_multipla        : more than one button was down at capture time
//   botoes_estaveis        : debounced button vector
//   db_estado              : FSM state code
module detector_jogada #(
  parameter int N_BOTOES        = 7,
  parameter int DEBOUNCE_CICLOS = 50000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_BOTOES-1:0] botoes,
  input  logic                habilita,
  input  logic                limpa_jogada,
  output logic                tem_botao_pressionado,
  output logic                tem_jogada,
  output logic [N_BOTOES-1:0] jogada,
  output logic                jogada_multipla,
  output logic [N_BOTOES-1:0] botoes_estaveis,
  output logic [1:0]          db_estado
);

  localparam int              CW      = $clog2(DEBOUNCE_CICLOS) + 1;
  localparam logic [CW-1:0]   CNT_FIM = CW'(DEBOUNCE_CICLOS - 1);
  localparam logic [CW-1:0]   CNT_SAT = CW'(DEBOUNCE_CICLOS);

  typedef enum logic [1:0] {
    ESPERA_SOLTO = 2'd0,
    PRONTO       = 2'd1,
    PRESSIONADO  = 2'd2,
    INVALIDO     = 2'd3
  } estado_t;

  logic [N_BOTOES-1:0] s1;
  logic [N_BOTOES-1:0] s2;
  logic [N_BOTOES-1:0] candidato;
  logic [CW-1:0]       cnt;
  logic                atualiza;

  estado_t             estado;
  estado_t             estado_prox;
  logic                captura;

  logic [N_BOTOES-1:0] menor_bit;
  logic                varios_bits;

  // Two-flop synchroniser followed by a restart-on-change debounce counter.
  // Once a vector is accepted the counter parks at DEBOUNCE_CICLOS so the
  // same candidate is written exactly once.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1              <= '0;
      s2              <= '0;
      candidato       <= '0;
      cnt             <= '0;
      botoes_estaveis <= '0;
    end else begin
      s1 <= botoes;
      s2 <= s1;
      if (s2 != candidato) begin
        candidato <= s2;
        cnt       <= '0;
      end else if (cnt == CNT_FIM) begin
        botoes_estaveis <= candidato;
        cnt             <= CNT_SAT;
      end else if (cnt < CNT_FIM) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Marks the edge on which candidato is being written into botoes_estaveis.
  assign atualiza = (s2 == candidato) && (cnt == CNT_FIM);

  // Lowest set bit via two's complement; more than one bit if clearing the
  // lowest one still leaves something set.
  assign menor_bit   = botoes_estaveis & (~botoes_estaveis + N_BOTOES'(1));
  assign varios_bits = (botoes_estaveis & (botoes_estaveis - N_BOTOES'(1))) != '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= ESPERA_SOLTO;
    end else begin
      estado <= estado_prox;
    end
  end

  always_comb begin
    estado_prox = estado;
    captura     = 1'b0;
    case (estado)
      // Only a debounced all-released vector arms the detector, so buttons
      // held through reset or through a disabled press never count.
      ESPERA_SOLTO: begin
        if (atualiza && (candidato == '0)) begin
          estado_prox = PRONTO;
        end
      end
      PRONTO: begin
        if (botoes_estaveis != '0) begin
          if (habilita) begin
            estado_prox = PRESSIONADO;
            captura     = 1'b1;
          end else begin
            estado_prox = ESPERA_SOLTO;
          end
        end
      end
      PRESSIONADO: begin
        if (botoes_estaveis == '0) begin
          estado_prox = PRONTO;
        end
      end
      default: begin
        estado_prox = ESPERA_SOLTO;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tem_jogada      <= 1'b0;
      jogada          <= '0;
      jogada_multipla <= 1'b0;
    end else begin
      tem_jogada <= captura;
      if (captura) begin
        jogada          <= menor_bit;
        jogada_multipla <= varios_bits;
      end else if (limpa_jogada) begin
        jogada          <= '0;
        jogada_multipla <= 1'b0;
      end
    end
  end

  assign tem_botao_pressionado = |botoes_estaveis;
  assign db_estado             = estado;

endmodule

// File: tb/tb_detector_jogada.sv
module tb_detector_jogada;

  localparam int N  = 7;
  localparam int DB = 4;

  logic         clock;
  logic         reset;
  logic [N-1:0] botoes;
  logic         habilita;
  logic         limpa_jogada;
  logic         tem_botao_pressionado;
  logic         tem_jogada;
  logic [N-1:0] jogada;
  logic         jogada_multipla;
  logic [N-1:0] botoes_estaveis;
  logic [1:0]   db_estado;

  typedef struct packed {
    logic [N-1:0] jog;
    logic         mul;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;
  int   n_cmp = 0;
  int   n_err = 0;

  detector_jogada #(
    .N_BOTOES        (N),
    .DEBOUNCE_CICLOS (DB)
  ) dut (
    .clock                 (clock),
    .reset                 (reset),
    .botoes                (botoes),
    .habilita              (habilita),
    .limpa_jogada          (limpa_jogada),
    .tem_botao_pressionado (tem_botao_pressionado),
    .tem_jogada            (tem_jogada),
    .jogada                (jogada),
    .jogada_multipla       (jogada_multipla),
    .botoes_estaveis       (botoes_estaveis),
    .db_estado             (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Scoreboard consumer: every pulse must match the oldest expected capture.
  always @(negedge clock) begin
    if (!reset && tem_jogada === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pulse: got jogada=%b multipla=%b, no pulse expected", jogada, jogada_multipla);
      end else begin
        e_mon = exp_q.pop_front();
        if ({jogada, jogada_multipla} !== {e_mon.jog, e_mon.mul}) begin
          n_err++;
          $display("FAIL pulse_capture: got jogada=%b multipla=%b, expected jogada=%b multipla=%b",
                   jogada, jogada_multipla, e_mon.jog, e_mon.mul);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; botoes = '0; habilita = 1'b1; limpa_jogada = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({botoes_estaveis, tem_jogada, jogada, jogada_multipla, tem_botao_pressionado} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got estaveis=%b tem=%b jogada=%b mul=%b tbp=%b, expected all 0",
               botoes_estaveis, tem_jogada, jogada, jogada_multipla, tem_botao_pressionado);
    end
    n_cmp++;
    if (db_estado !== 2'd0) begin
      n_err++;
      $display("FAIL reset_state: got %0d expected 0", db_estado);
    end
    reset = 1'b0;
    repeat (12) tick();
    n_cmp++;
    if (db_estado !== 2'd1) begin
      n_err++;
      $display("FAIL idle_armed: got %0d expected 1", db_estado);
    end
  endtask

  task automatic test_press_clean();
    logic [N-1:0] v;
    v = 7'b0000100;
    botoes = v;
    exp_q.push_back('{jog: 7'b0000100, mul: 1'b0});
    for (int k = 1; k <= 12; k++) begin
      tick();
      n_cmp++;
      if (botoes_estaveis !== ((k >= DB + 3) ? v : 7'b0)) begin
        n_err++;
        $display("FAIL clean_estaveis k=%0d: got %b expected %b", k, botoes_estaveis, (k >= DB + 3) ? v : 7'b0);
      end
      n_cmp++;
      if (tem_jogada !== (k == DB + 4)) begin
        n_err++;
        $display("FAIL clean_pulse_timing k=%0d: got %b expected %b", k, tem_jogada, (k == DB + 4));
      end
      n_cmp++;
      if (db_estado !== ((k >= DB + 4) ? 2'd2 : 2'd1)) begin
        n_err++;
        $display("FAIL clean_state k=%0d: got %0d expected %0d", k, db_estado, (k >= DB + 4) ? 2 : 1);
      end
      n_cmp++;
      if (tem_botao_pressionado !== (k >= DB + 3)) begin
        n_err++;
        $display("FAIL clean_tbp k=%0d: got %b expected %b", k, tem_botao_pressionado, (k >= DB + 3));
      end
    end
    n_cmp++;
    if ({jogada, jogada_multipla} !== {7'b0000100, 1'b0}) begin
      n_err++;
      $display("FAIL clean_hold: got jogada=%b mul=%b expected 0000100 0", jogada, jogada_multipla);
    end
    botoes = '0;
    repeat (12) tick();
    n_cmp++;
    if (db_estado !== 2'd1 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL clean_release: got state=%0d pending=%0d expected state=1 pending=0", db_estado, exp_q.size());
    end
  endtask

  task automatic test_bounce();
    for (int k = 0; k < 20; k++) begin
      if (k % 2 == 0) botoes[5] = ~botoes[5];
      tick();
      n_cmp++;
      if (botoes_estaveis !== 7'b0) begin
        n_err++;
        $display("FAIL bounce_estaveis k=%0d: got %b expected 0000000", k, botoes_estaveis);
      end
    end
    botoes = '0;
    repeat (12) tick();
    n_cmp++;
    if (botoes_estaveis !== 7'b0 || db_estado !== 2'd1) begin
      n_err++;
      $display("FAIL bounce_settle: got estaveis=%b state=%0d expected 0000000 1", botoes_estaveis, db_estado);
    end
  endtask

  task automatic test_multiple();
    botoes = 7'b0010010;
    exp_q.push_back('{jog: 7'b0000010, mul: 1'b1});
    repeat (12) tick();
    n_cmp++;
    if ({jogada, jogada_multipla, db_estado} !== {7'b0000010, 1'b1, 2'd2}) begin
      n_err++;
      $display("FAIL multi_capture: got jogada=%b mul=%b state=%0d expected 0000010 1 2", jogada, jogada_multipla, db_estado);
    end
    botoes = '0;
    repeat (12) tick();
    botoes = 7'b1000000;
    exp_q.push_back('{jog: 7'b1000000, mul: 1'b0});
    repeat (12) tick();
    n_cmp++;
    if ({jogada, jogada_multipla} !== {7'b1000000, 1'b0}) begin
      n_err++;
      $display("FAIL second_capture: got jogada=%b mul=%b expected 1000000 0", jogada, jogada_multipla);
    end
    botoes = '0;
    repeat (12) tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL multi_pending: got %0d expected 0", exp_q.size());
    end
  endtask

  task automatic test_hold_through_reset();
    reset = 1'b1;
    botoes = 7'b0001000;
    repeat (3) tick();
    reset = 1'b0;
    repeat (20) tick();
    n_cmp++;
    if ({db_estado, botoes_estaveis, jogada} !== {2'd0, 7'b0001000, 7'b0}) begin
      n_err++;
      $display("FAIL held_reset: got state=%0d estaveis=%b jogada=%b expected 0 0001000 0000000",
               db_estado, botoes_estaveis, jogada);
    end
    botoes = '0;
    repeat (12) tick();
    n_cmp++;
    if (db_estado !== 2'd1) begin
      n_err++;
      $display("FAIL held_release: got %0d expected 1", db_estado);
    end
    botoes = 7'b0001000;
    exp_q.push_back('{jog: 7'b0001000, mul: 1'b0});
    repeat (12) tick();
    botoes = '0;
    repeat (12) tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL held_repress: got pending=%0d expected 0", exp_q.size());
    end
  endtask

  task automatic test_habilita();
    habilita = 1'b0;
    botoes = 7'b0000001;
    repeat (12) tick();
    n_cmp++;
    if (db_estado !== 2'd0) begin
      n_err++;
      $display("FAIL disabled_state: got %0d expected 0", db_estado);
    end
    habilita = 1'b1;
    repeat (12) tick();
    n_cmp++;
    if (db_estado !== 2'd0) begin
      n_err++;
      $display("FAIL enabled_held: got %0d expected 0", db_estado);
    end
    botoes = '0;
    repeat (12) tick();
    n_cmp++;
    if (db_estado !== 2'd1) begin
      n_err++;
      $display("FAIL enabled_release: got %0d expected 1", db_estado);
    end
    botoes = 7'b0000001;
    exp_q.push_back('{jog: 7'b0000001, mul: 1'b0});
    repeat (12) tick();
    botoes = '0;
    repeat (12) tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL enabled_repress: got pending=%0d expected 0", exp_q.size());
    end
  endtask

  task automatic test_limpa();
    botoes = 7'b0110000;
    exp_q.push_back('{jog: 7'b0010000, mul: 1'b1});
    for (int k = 1; k <= DB + 5; k++) begin
      tick();
      // Raise limpa so it is sampled on the capture edge, then keep it one more edge.
      if (k == DB + 3) limpa_jogada = 1'b1;
      if (k == DB + 4) begin
        n_cmp++;
        if ({jogada, jogada_multipla} !== {7'b0010000, 1'b1}) begin
          n_err++;
          $display("FAIL limpa_same_edge: got jogada=%b mul=%b expected 0010000 1", jogada, jogada_multipla);
        end
      end
      if (k == DB + 5) begin
        limpa_jogada = 1'b0;
        n_cmp++;
        if ({jogada, jogada_multipla, db_estado} !== {7'b0, 1'b0, 2'd2}) begin
          n_err++;
          $display("FAIL limpa_after: got jogada=%b mul=%b state=%0d expected 0000000 0 2",
                   jogada, jogada_multipla, db_estado);
        end
      end
    end
    botoes = '0;
    repeat (12) tick();
    n_cmp++;
    if (exp_q.size() != 0 || db_estado !== 2'd1) begin
      n_err++;
      $display("FAIL limpa_release: got pending=%0d state=%0d expected 0 1", exp_q.size(), db_estado);
    end
  endtask

  initial begin
    reset = 1'b1; botoes = '0; habilita = 1'b1; limpa_jogada = 1'b0;
    test_reset();
    test_press_clean();
    test_bounce();
    test_multiple();
    test_hold_through_reset();
    test_habilita();
    test_limpa();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/detector_jogada.md
Name: detector_jogada

Overview:
Conditions the raw note buttons for the game control FSM. It synchronises and debounces the button vector and exposes a level `tem_botao_pressionado`. It emits a one-cycle `tem_jogada` pulse per accepted press and holds the pressed button as a one-hot `jogada` code. It sits between the board pins and the control unit; `jogada` feeds the button register that the control unit enables.

Parameters:
N_BOTOES, 7, number of note buttons (width of button vectors); minimum 1
DEBOUNCE_CICLOS, 50000, consecutive stable clock cycles needed to accept a new button vector; minimum 2

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
botoes  input  N_BOTOES  raw asynchronous buttons, 1 = pressed
habilita  input  1  1 = presses may generate jogadas; 0 = presses are ignored
limpa_jogada  input  1  synchronous clear of jogada and jogada_multipla
tem_botao_pressionado  output  1  OR of botoes_estaveis
tem_jogada  output  1  one-cycle pulse on each accepted press
jogada  output  N_BOTOES  one-hot code of accepted button (lowest index if several), held until next jogada or clear
jogada_multipla  output  1  1 if more than one bit was set when jogada was captured
botoes_estaveis  output  N_BOTOES  debounced button vector
db_estado  output  2  current FSM state code

Behaviour:
- Reset (reset=1 at an edge): all registers cleared; outputs 0; FSM = ESPERA_SOLTO; debounce counter = 0. Reset mid-press aborts any jogada in progress.
- Synchroniser: two flops per bit, s1 and s2. A raw change is visible in s2 two edges after it appears.
- Debounce: one candidate register and one counter (width clog2(DEBOUNCE_CICLOS)+1).
  - If s2 != candidate: candidate <= s2, cnt <= 0.
  - Else if cnt == DEBOUNCE_CICLOS-1: botoes_estaveis <= candidate, internal atualiza = 1 for that edge, cnt <= DEBOUNCE_CICLOS (saturates, no further writes).
  - Else if cnt < DEBOUNCE_CICLOS-1: cnt++.
- Latency: a clean input change sampled at edge 1 appears in botoes_estaveis at edge DEBOUNCE_CICLOS+3. Any glitch shorter than DEBOUNCE_CICLOS cycles in s2 restarts the count and is never accepted.
- FSM states, codes in db_estado:
  - ESPERA_SOLTO=0: goes to PRONTO on an edge where atualiza=1 and the written value is 0. Any nonzero acceptance keeps it here.
  - PRONTO=1: goes to PRESSIONADO when botoes_estaveis != 0. If habilita=1 at that edge, also set tem_jogada=1 for the next cycle, jogada <= lowest set bit of botoes_estaveis, and jogada_multipla <= (popcount > 1). If habilita=0, go to ESPERA_SOLTO instead, with no pulse and no capture.
  - PRESSIONADO=2: goes to PRONTO when botoes_estaveis == 0. Extra buttons added or changed while here generate no new jogada.
  - Code 3 is unused and recovers to ESPERA_SOLTO.
- Buttons held through reset never produce a jogada until all buttons are released and the release is debounced.
- tem_jogada is registered, high exactly one cycle, and asserted the edge after botoes_estaveis becomes nonzero (edge DEBOUNCE_CICLOS+4 after sampling).
- limpa_jogada clears jogada and jogada_multipla and does not affect FSM state. If a capture and limpa_jogada fall on the same edge, the capture wins.
- tem_botao_pressionado is combinational from botoes_estaveis.

Test Plan (DEBOUNCE_CICLOS=4, N_BOTOES=7):
- Reset with botoes=0, then press bit 2 cleanly at edge 10 with habilita=1 -> botoes_estaveis=7'b0000100 at edge 17; tem_jogada high only at edge 18; jogada=7'b0000100; jogada_multipla=0; db_estado 1 then 2.
- Bounce: toggle bit 5 every 2 cycles for 20 cycles, then hold 0 -> botoes_estaveis stays 0; tem_jogada never asserted.
- Press bits 1 and 4 together -> jogada=7'b0000010, jogada_multipla=1. Release and press bit 6 -> second pulse, jogada=7'b1000000, jogada_multipla=0.
- Hold bit 3 through a reset -> no tem_jogada while held; db_estado=0. Release, then press bit 3 again -> exactly one pulse.
- habilita=0 during a press -> no pulse, db_estado goes to 0. Set habilita=1 while still held -> no pulse. After release and re-press -> one pulse.
- limpa_jogada asserted on the same edge as a capture -> jogada holds the new code. limpa_jogada one cycle later -> jogada=0, jogada_multipla=0, db_estado unchanged (2).
